// File: rtl/seq_comparator_if.sv
// Operand/result bundle for the chunked sequential comparator.
// start, is_signed, a and b are sampled on the rising clock edge; results hold until the next accepted start.
interface seq_comparator_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             lt;
    logic             eq;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, gt, lt, eq
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, gt, lt, eq
    );
endinterface

// File: rtl/seq_comparator.sv
// Sequential magnitude comparator: checks one CHUNK-bit slice per cycle, MS slice first, and stops early
// on the first unequal slice. done pulses for one cycle; gt/lt/eq hold until the next accepted start.
module seq_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    seq_comparator_if.slave    bus,
    output logic [1:0]         dbg_state
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             lt_q;
    logic             eq_q;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic             slice_gt;
    logic             slice_lt;

    // Inverting the sign bit maps two's complement onto unsigned order, so one comparator serves both modes.
    always_comb begin
        slice_a = a_q[idx*CHUNK +: CHUNK];
        slice_b = b_q[idx*CHUNK +: CHUNK];
        if (sgn_q && (idx == TOP_IDX)) begin
            slice_a[CHUNK-1] = ~slice_a[CHUNK-1];
            slice_b[CHUNK-1] = ~slice_b[CHUNK-1];
        end
        slice_gt = (slice_a > slice_b);
        slice_lt = (slice_a < slice_b);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        sgn_q  <= bus.is_signed;
                        idx    <= TOP_IDX;
                        gt_q   <= 1'b0;
                        lt_q   <= 1'b0;
                        eq_q   <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (slice_gt || slice_lt || (idx == '0)) begin
                        gt_q   <= slice_gt;
                        lt_q   <= slice_lt;
                        eq_q   <= ~(slice_gt | slice_lt);
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.gt    = gt_q;
    assign bus.lt    = lt_q;
    assign bus.eq    = eq_q;
    assign dbg_state = state;
endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator (WIDTH=32, CHUNK=8): directed vectors push {busy_cycles, gt, lt, eq} expectations;
// a monitor pops one expectation per done pulse and compares.
module tb_seq_comparator;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int W     = 8;

    logic       clk;
    logic       n_rst;
    logic [1:0] dbg_state;

    seq_comparator_if #(.WIDTH(WIDTH)) bus ();

    seq_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int total     = 0;
    int bad       = 0;
    int done_cnt  = 0;
    int busy_cnt  = 0;
    int cyc       = 0;
    int last_done = 0;
    int done_gap  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // monitor / scoreboard
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        cyc++;
        if (!n_rst) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_gap  = cyc - last_done;
                last_done = cyc;
                check("onehot", 32'($countones({bus.gt, bus.lt, bus.eq})), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_gt_lt_eq", 32'({bus.gt, bus.lt, bus.eq}), 32'(e[2:0]));
                    check("busy_cycles", 32'(busy_cnt), 32'(e[7:3]));
                end
                busy_cnt = 0;
            end
        end
    end

    // driver tasks
    task automatic wait_dones(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic run_cmp(input logic [31:0] av, input logic [31:0] bv, input logic sgn,
                           input logic [2:0] res, input int cycles);
        int tgt;
        @(negedge clk);
        tgt = done_cnt + 1;
        exp_q.push_back({5'(cycles), res});
        bus.start     = 1'b1;
        bus.a         = av;
        bus.b         = bv;
        bus.is_signed = sgn;
        @(negedge clk);
        bus.start = 1'b0;
        wait_dones(tgt);
    endtask

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_EQ = 3'b001;

    initial begin
        int tgt;
        n_rst         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({dbg_state, bus.busy, bus.done, bus.gt, bus.lt, bus.eq}), 32'd0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        run_cmp(32'h12345678, 32'h12345679, 1'b0, R_LT, 4);
        run_cmp(32'h80000000, 32'h00000001, 1'b0, R_GT, 1);
        run_cmp(32'h80000000, 32'h00000001, 1'b1, R_LT, 1);
        run_cmp(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, R_GT, 4);
        run_cmp(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, R_EQ, 4);
        repeat (3) @(negedge clk);
        check("eq_hold_idle", 32'({dbg_state, bus.done, bus.gt, bus.lt, bus.eq}), 32'b00_0_001);

        // second start during COMPARE must be ignored
        @(negedge clk);
        tgt = done_cnt + 1;
        exp_q.push_back({5'd4, R_LT});
        bus.start = 1'b1; bus.a = 32'h12345678; bus.b = 32'h12345679; bus.is_signed = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'hFFFFFFFF; bus.b = 32'h00000000;
        @(negedge clk);
        bus.start = 1'b0;
        wait_dones(tgt);
        repeat (6) @(negedge clk);
        check("ignored_start_no_extra_done", 32'(done_cnt), 32'(tgt));

        // held start: back-to-back comparisons every j+2 cycles
        @(negedge clk);
        tgt = done_cnt + 2;
        exp_q.push_back({5'd1, R_GT});
        exp_q.push_back({5'd1, R_GT});
        bus.start = 1'b1; bus.a = 32'h80000000; bus.b = 32'h00000001; bus.is_signed = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_dones(tgt);
        check("back_to_back_gap", 32'(done_gap), 32'd3);

        // asynchronous reset during the 2nd COMPARE cycle
        @(negedge clk);
        tgt = done_cnt;
        bus.start = 1'b1; bus.a = 32'hDEADBEEF; bus.b = 32'hDEADBEEF; bus.is_signed = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        check("mid_compare_state", 32'({dbg_state, bus.busy}), 32'b01_1);
        n_rst = 1'b0;
        #1;
        check("async_reset_outputs", 32'({dbg_state, bus.busy, bus.done, bus.gt, bus.lt, bus.eq}), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (6) @(negedge clk);
        check("no_done_after_abort", 32'(done_cnt), 32'(tgt));
        run_cmp(32'd5, 32'd3, 1'b0, R_GT, 4);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
